// File: rtl/rei_trap_csr.sv
// rei_trap_csr: machine-mode trap and CSR unit for the rei core.
//
// Holds mstatus/misa/mie/mtvec/mscratch/mepc/mcause/mtval/mip/mhartid plus
// the 64-bit mcycle/minstret counters. Each cycle it picks at most one of
// exception > interrupt > mret > CSR write, and drives the fetch redirect.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   csr_valid/addr/op/wdata     CSR access (op: 00 read, 01 write, 10 set, 11 clear)
//   csr_rdata, csr_illegal      pre-write CSR value, illegal-access flag
//   retire_valid                instruction retired (minstret increment)
//   boundary                    interrupt may be accepted this cycle
//   exc_valid/cause/tval/pc     synchronous exception report (pc also used for interrupts)
//   mret                        mret executing
//   irq_msip/mtip/meip          level interrupt sources, registered into mip
//   redirect_valid/pc           trap or mret taken, target PC
//   irq_pending                 enabled interrupt pending with mstatus.MIE set
module rei_trap_csr #(
    parameter int unsigned      XLEN        = 64,
    parameter int unsigned      HARTID      = 0,
    parameter logic [XLEN-1:0]  MTVEC_RESET = XLEN'('h80000000),
    parameter bit               VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            retire_valid,
    input  logic            boundary,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            irq_pending
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    localparam logic [XLEN-1:0] MTVEC_RST =
        {MTVEC_RESET[XLEN-1:2], 1'b0, MTVEC_RESET[0] & VECTORED_EN};

    // Interrupt vectors are kept compact: [0]=MSI(bit 3), [1]=MTI(bit 7), [2]=MEI(bit 11)
    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;
    logic [2:0]      mip_q, mip_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic [63:0]     mstatus64;
    logic [XLEN-1:0] misa_rd;
    logic [XLEN-1:0] rd_val;
    logic            impl;
    logic            csr_wr;
    logic            illegal_raw;
    logic            csr_we;
    logic [XLEN-1:0] csr_new;
    logic [2:0]      irq_act;
    logic            irq_pend_int;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;
    logic            take_exc, take_irq, take_mret, take_trap;
    logic [XLEN-1:0] trap_target;

    function automatic logic [XLEN-1:0] irq_bits(input logic [2:0] v);
        logic [XLEN-1:0] r;
        r     = '0;
        r[3]  = v[0];
        r[7]  = v[1];
        r[11] = v[2];
        return r;
    endfunction

    // Read-only constant fields
    always_comb begin
        mstatus64        = 64'h0000_0000_0000_1800;
        if (XLEN == 64) mstatus64[35:32] = 4'hA;
        mstatus64[3]     = mstatus_mie_q;
        mstatus64[7]     = mstatus_mpie_q;
        misa_rd          = '0;
        misa_rd[XLEN-1 -: 2] = (XLEN == 64) ? 2'b10 : 2'b01;
        misa_rd[8]       = 1'b1;
    end

    always_comb begin
        rd_val = '0;
        impl   = 1'b1;
        case (csr_addr)
            A_MSTATUS:   rd_val = mstatus64[XLEN-1:0];
            A_MISA:      rd_val = misa_rd;
            A_MIE:       rd_val = irq_bits(mie_q);
            A_MTVEC:     rd_val = mtvec_q;
            A_MSCRATCH:  rd_val = mscratch_q;
            A_MEPC:      rd_val = mepc_q;
            A_MCAUSE:    rd_val = mcause_q;
            A_MTVAL:     rd_val = mtval_q;
            A_MIP:       rd_val = irq_bits(mip_q);
            A_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
            A_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
            A_MCYCLEH: begin
                if (XLEN == 32) rd_val = XLEN'(mcycle_q[63:32]);
                else            impl   = 1'b0;
            end
            A_MINSTRETH: begin
                if (XLEN == 32) rd_val = XLEN'(minstret_q[63:32]);
                else            impl   = 1'b0;
            end
            A_MHARTID:   rd_val = XLEN'(HARTID);
            default:     impl   = 1'b0;
        endcase
    end

    assign csr_rdata = rd_val;

    // Set/clear with a zero operand is a pure read and never counts as a write
    assign csr_wr      = csr_valid && ((csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0)));
    assign illegal_raw = csr_valid && (!impl || ((csr_addr == A_MHARTID) && csr_wr));
    assign csr_illegal = !rst && illegal_raw;

    always_comb begin
        case (csr_op)
            2'b01:   csr_new = csr_wdata;
            2'b10:   csr_new = rd_val | csr_wdata;
            2'b11:   csr_new = rd_val & ~csr_wdata;
            default: csr_new = rd_val;
        endcase
    end

    // Interrupt arbitration: MEI > MSI > MTI
    assign irq_act      = mip_q & mie_q;
    assign irq_pend_int = mstatus_mie_q && (irq_act != 3'b000);
    assign irq_pending  = !rst && irq_pend_int;

    always_comb begin
        if (irq_act[2])      irq_code = 4'd11;
        else if (irq_act[0]) irq_code = 4'd3;
        else                 irq_code = 4'd7;
        irq_cause           = XLEN'(irq_code);
        irq_cause[XLEN-1]   = 1'b1;
    end

    assign take_exc  = !rst && exc_valid;
    assign take_irq  = !rst && !exc_valid && boundary && irq_pend_int;
    assign take_mret = !rst && !exc_valid && !take_irq && mret;
    assign take_trap = take_exc || take_irq;
    assign csr_we    = csr_wr && !illegal_raw && !take_trap && !take_mret;

    always_comb begin
        trap_target = {mtvec_q[XLEN-1:2], 2'b00};
        if (take_irq && mtvec_q[0])
            trap_target = trap_target + XLEN'({irq_code, 2'b00});
    end

    assign redirect_valid = take_trap || take_mret;
    assign redirect_pc    = take_trap ? trap_target : (take_mret ? mepc_q : '0);

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mip_d          = {irq_meip, irq_mtip, irq_msip};
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        mcycle_d       = mcycle_q + 64'd1;
        minstret_d     = minstret_q + {63'd0, retire_valid};

        if (take_trap) begin
            mepc_d         = {exc_pc[XLEN-1:2], 2'b00};
            mcause_d       = take_exc ? exc_cause : irq_cause;
            mtval_d        = take_exc ? exc_tval : '0;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else if (take_mret) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                A_MSTATUS: begin
                    mstatus_mie_d  = csr_new[3];
                    mstatus_mpie_d = csr_new[7];
                end
                A_MIE:      mie_d      = {csr_new[11], csr_new[7], csr_new[3]};
                A_MTVEC:    mtvec_d    = {csr_new[XLEN-1:2], 1'b0, csr_new[0] & VECTORED_EN};
                A_MSCRATCH: mscratch_d = csr_new;
                A_MEPC:     mepc_d     = {csr_new[XLEN-1:2], 2'b00};
                A_MCAUSE:   mcause_d   = csr_new;
                A_MTVAL:    mtval_d    = csr_new;
                // A counter write replaces the increment; the untouched half keeps its old value
                A_MCYCLE: begin
                    mcycle_d             = mcycle_q;
                    mcycle_d[XLEN-1:0]   = csr_new;
                end
                A_MINSTRET: begin
                    minstret_d           = minstret_q;
                    minstret_d[XLEN-1:0] = csr_new;
                end
                A_MCYCLEH: begin
                    mcycle_d             = mcycle_q;
                    mcycle_d[63:32]      = csr_new[31:0];
                end
                A_MINSTRETH: begin
                    minstret_d           = minstret_q;
                    minstret_d[63:32]    = csr_new[31:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RST;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_rei_trap_csr.sv
// Scoreboard bench for rei_trap_csr: stimulus pushes expected CSR responses
// and redirect targets into queues; negedge monitors pop and compare whenever
// a CSR access or redirect is presented. A second XLEN=32 instance covers
// the split counter halves and hardwired mtvec MODE.
module tb_rei_trap_csr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // 64-bit instance signals
    logic        csr_valid = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [1:0]  csr_op = '0;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata;
    logic        csr_illegal;
    logic        retire_valid = 1'b0;
    logic        boundary = 1'b0;
    logic        exc_valid = 1'b0;
    logic [63:0] exc_cause = '0;
    logic [63:0] exc_tval = '0;
    logic [63:0] exc_pc = '0;
    logic        mret = 1'b0;
    logic        irq_msip = 1'b0, irq_mtip = 1'b0, irq_meip = 1'b0;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        irq_pending;

    // 32-bit instance signals
    logic        c32_valid = 1'b0;
    logic [11:0] c32_addr = '0;
    logic [1:0]  c32_op = '0;
    logic [31:0] c32_wdata = '0;
    logic [31:0] c32_rdata;
    logic        c32_illegal;
    logic        c32_rv;
    logic [31:0] c32_rpc;
    logic        c32_ip;
    logic [31:0] zero32 = '0;

    rei_trap_csr #(.XLEN(64), .HARTID(3), .MTVEC_RESET(64'h8000_0000), .VECTORED_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .csr_valid(csr_valid), .csr_addr(csr_addr), .csr_op(csr_op), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
        .retire_valid(retire_valid), .boundary(boundary),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval), .exc_pc(exc_pc),
        .mret(mret), .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .irq_pending(irq_pending)
    );

    rei_trap_csr #(.XLEN(32), .HARTID(0), .MTVEC_RESET(32'h8000_0000), .VECTORED_EN(1'b0)) dut32 (
        .clk(clk), .rst(rst),
        .csr_valid(c32_valid), .csr_addr(c32_addr), .csr_op(c32_op), .csr_wdata(c32_wdata),
        .csr_rdata(c32_rdata), .csr_illegal(c32_illegal),
        .retire_valid(1'b0), .boundary(1'b0),
        .exc_valid(1'b0), .exc_cause(zero32), .exc_tval(zero32), .exc_pc(zero32),
        .mret(1'b0), .irq_msip(1'b0), .irq_mtip(1'b0), .irq_meip(1'b0),
        .redirect_valid(c32_rv), .redirect_pc(c32_rpc), .irq_pending(c32_ip)
    );

    typedef struct {
        logic [63:0] rd;
        bit          chk_rd;
        bit          ill;
        bit          ip;
        bit          rv;
    } rec_t;

    rec_t        exp_q[$];
    string       nm_q[$];
    logic [63:0] redir_q[$];
    rec_t        exp32_q[$];
    string       nm32_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One CSR access cycle on the 64-bit instance; expectation goes to the scoreboard
    task automatic acc(input logic [11:0] a, input logic [1:0] op, input logic [63:0] wd,
                       input logic [63:0] rd, input bit chk_rd, input bit ill,
                       input bit ip, input bit rv, input string nm);
        rec_t r;
        r = '{rd: rd, chk_rd: chk_rd, ill: ill, ip: ip, rv: rv};
        exp_q.push_back(r);
        nm_q.push_back(nm);
        csr_valid = 1'b1; csr_addr = a; csr_op = op; csr_wdata = wd;
        @(posedge clk); #1;
        csr_valid = 1'b0; csr_op = '0; csr_wdata = '0;
    endtask

    task automatic acc32(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                         input logic [63:0] rd, input bit chk_rd, input bit ill, input string nm);
        rec_t r;
        r = '{rd: rd, chk_rd: chk_rd, ill: ill, ip: 1'b0, rv: 1'b0};
        exp32_q.push_back(r);
        nm32_q.push_back(nm);
        c32_valid = 1'b1; c32_addr = a; c32_op = op; c32_wdata = wd;
        @(posedge clk); #1;
        c32_valid = 1'b0; c32_op = '0; c32_wdata = '0;
    endtask

    rec_t  m_exp, m32_exp;
    string m_nm, m32_nm;

    always @(negedge clk) begin
        if (csr_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL csr_unexpected: access with no expected entry (t=%0t)", $time);
            end else begin
                m_exp = exp_q.pop_front();
                m_nm  = nm_q.pop_front();
                if (m_exp.chk_rd) check({m_nm, "/rdata"}, csr_rdata, m_exp.rd);
                check({m_nm, "/illegal"}, 64'(csr_illegal), 64'(m_exp.ill));
                check({m_nm, "/irq_pending"}, 64'(irq_pending), 64'(m_exp.ip));
                check({m_nm, "/redirect_valid"}, 64'(redirect_valid), 64'(m_exp.rv));
            end
        end
        if (redirect_valid) begin
            if (redir_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL redirect_unexpected: pc %h (t=%0t)", redirect_pc, $time);
            end else begin
                check("redirect_pc", redirect_pc, redir_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (c32_valid) begin
            if (exp32_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL csr32_unexpected: access with no expected entry (t=%0t)", $time);
            end else begin
                m32_exp = exp32_q.pop_front();
                m32_nm  = nm32_q.pop_front();
                if (m32_exp.chk_rd) check({m32_nm, "/rdata"}, {32'd0, c32_rdata}, m32_exp.rd);
                check({m32_nm, "/illegal"}, 64'(c32_illegal), 64'(m32_exp.ill));
                check({m32_nm, "/redirect_valid"}, 64'(c32_rv), 64'(0));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk); #1;
        // Reset: outputs gated, csr_rdata shows reset state, in-flight exception ignored
        exc_valid = 1'b1; exc_pc = 64'h5000;
        acc(12'h305, 2'b00, 0, 64'h8000_0000, 1, 0, 0, 0, "rst_mtvec");
        acc(12'h7C0, 2'b00, 0, 0, 0, 0, 0, 0, "rst_illegal_gated");
        exc_valid = 1'b0; rst = 1'b0;

        acc(12'h300, 2'b00, 0, 64'h0000000a_00001800, 1, 0, 0, 0, "mstatus_reset");
        acc(12'hF14, 2'b00, 0, 64'd3, 1, 0, 0, 0, "mhartid");
        acc(12'h7C0, 2'b00, 0, 0, 0, 1, 0, 0, "unimpl_addr");
        acc(12'h301, 2'b00, 0, 64'h80000000_00000100, 1, 0, 0, 0, "misa64");
        acc(12'h305, 2'b01, 64'h8000_0101, 64'h8000_0000, 1, 0, 0, 0, "mtvec_wr");
        acc(12'h305, 2'b00, 0, 64'h8000_0101, 1, 0, 0, 0, "mtvec_rd");
        acc(12'h304, 2'b10, 64'h800, 0, 1, 0, 0, 0, "mie_set");
        acc(12'h300, 2'b10, 64'h8, 64'h0000000a_00001800, 1, 0, 0, 0, "mstatus_set_mie");
        irq_meip = 1'b1;
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001808, 1, 0, 0, 0, "irq_not_yet_visible");
        acc(12'h344, 2'b00, 0, 64'h800, 1, 0, 1, 0, "mip_meip");

        // Vectored interrupt; same-cycle mscratch write must be dropped
        boundary = 1'b1; exc_pc = 64'h1236;
        redir_q.push_back(64'h8000_012C);
        acc(12'h340, 2'b01, 64'h55, 0, 1, 0, 1, 1, "irq_take");
        boundary = 1'b0;
        acc(12'h342, 2'b00, 0, 64'h80000000_0000000B, 1, 0, 0, 0, "irq_mcause");
        acc(12'h341, 2'b00, 0, 64'h1234, 1, 0, 0, 0, "irq_mepc");
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001880, 1, 0, 0, 0, "irq_mstatus");
        acc(12'h340, 2'b00, 0, 0, 1, 0, 0, 0, "mscratch_dropped");
        acc(12'h343, 2'b00, 0, 0, 1, 0, 0, 0, "irq_mtval");

        // Exception beats a pending interrupt
        acc(12'h300, 2'b10, 64'h8, 64'h0000000a_00001880, 1, 0, 0, 0, "reenable_mie");
        exc_valid = 1'b1; exc_cause = 64'd2; exc_tval = 64'hdead; exc_pc = 64'h2000; boundary = 1'b1;
        redir_q.push_back(64'h8000_0100);
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001888, 1, 0, 1, 1, "exc_over_irq");
        exc_valid = 1'b0; boundary = 1'b0; exc_tval = '0;
        acc(12'h342, 2'b00, 0, 64'd2, 1, 0, 0, 0, "exc_mcause");
        acc(12'h343, 2'b00, 0, 64'hdead, 1, 0, 0, 0, "exc_mtval");
        acc(12'h344, 2'b00, 0, 64'h800, 1, 0, 0, 0, "irq_still_pending");

        // mret
        mret = 1'b1;
        redir_q.push_back(64'h2000);
        acc(12'h341, 2'b00, 0, 64'h2000, 1, 0, 0, 1, "mret_take");
        mret = 1'b0;
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001888, 1, 0, 1, 0, "mret_mstatus");
        irq_meip = 1'b0;
        acc(12'h344, 2'b00, 0, 64'h800, 1, 0, 1, 0, "mip_lag");
        acc(12'h344, 2'b00, 0, 0, 1, 0, 0, 0, "mip_clear");

        // Counters
        acc(12'hB00, 2'b01, '1, 0, 0, 0, 0, 0, "mcycle_wr");
        acc(12'hB00, 2'b00, 0, '1, 1, 0, 0, 0, "mcycle_ones");
        acc(12'hB00, 2'b00, 0, 0, 1, 0, 0, 0, "mcycle_wrap");
        retire_valid = 1'b1;
        acc(12'hB02, 2'b01, 64'd5, 0, 0, 0, 0, 0, "minstret_wr");
        acc(12'hB02, 2'b00, 0, 64'd5, 1, 0, 0, 0, "minstret_write_wins");
        retire_valid = 1'b0;
        acc(12'hB02, 2'b00, 0, 64'd6, 1, 0, 0, 0, "minstret_inc");

        // Legality
        acc(12'hF14, 2'b10, 0, 64'd3, 1, 0, 0, 0, "mhartid_set0_legal");
        acc(12'hF14, 2'b11, 64'd1, 0, 0, 1, 0, 0, "mhartid_clear_illegal");
        acc(12'hF14, 2'b01, 0, 0, 0, 1, 0, 0, "mhartid_write_illegal");
        acc(12'hB80, 2'b00, 0, 0, 0, 1, 0, 0, "mcycleh_rv64_illegal");

        acc(12'h341, 2'b01, 64'h1003, 64'h2000, 1, 0, 0, 0, "mepc_wr");
        acc(12'h341, 2'b00, 0, 64'h1000, 1, 0, 0, 0, "mepc_align");
        acc(12'h304, 2'b01, '1, 64'h800, 1, 0, 0, 0, "mie_wr_all");
        acc(12'h304, 2'b00, 0, 64'h888, 1, 0, 0, 0, "mie_mask");
        acc(12'h304, 2'b11, 64'h80, 64'h888, 1, 0, 0, 0, "mie_clear");
        acc(12'h304, 2'b00, 0, 64'h808, 1, 0, 0, 0, "mie_after_clear");

        // Exception with same-cycle mepc write: old value read, write dropped
        exc_valid = 1'b1; exc_cause = 64'd5; exc_pc = 64'h3000;
        redir_q.push_back(64'h8000_0100);
        acc(12'h341, 2'b01, 64'h4444, 64'h1000, 1, 0, 0, 1, "exc_mepc_access");
        exc_valid = 1'b0;
        acc(12'h341, 2'b00, 0, 64'h3000, 1, 0, 0, 0, "exc_mepc_result");
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001880, 1, 0, 0, 0, "exc_mstatus");

        // Reset with an exception in flight
        exc_valid = 1'b1; exc_pc = 64'h5000;
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exc_valid = 1'b0;
        acc(12'h341, 2'b00, 0, 0, 1, 0, 0, 0, "rst2_mepc");
        acc(12'h300, 2'b00, 0, 64'h0000000a_00001800, 1, 0, 0, 0, "rst2_mstatus");
        acc(12'h305, 2'b00, 0, 64'h8000_0000, 1, 0, 0, 0, "rst2_mtvec");
        acc(12'h304, 2'b00, 0, 0, 1, 0, 0, 0, "rst2_mie");

        // XLEN=32 instance
        acc32(12'h301, 2'b00, 0, 64'h4000_0100, 1, 0, "rv32_misa");
        acc32(12'h300, 2'b00, 0, 64'h1800, 1, 0, "rv32_mstatus");
        acc32(12'h305, 2'b01, 32'h8000_0101, 64'h8000_0000, 1, 0, "rv32_mtvec_wr");
        acc32(12'h305, 2'b00, 0, 64'h8000_0100, 1, 0, "rv32_mtvec_mode0");
        acc32(12'hB80, 2'b01, 32'h1234_5678, 0, 0, 0, "rv32_mcycleh_wr");
        acc32(12'hB80, 2'b00, 0, 64'h1234_5678, 1, 0, "rv32_mcycleh_kept");
        acc32(12'hB00, 2'b01, 32'hFFFF_FFFF, 0, 0, 0, "rv32_mcycle_wr");
        acc32(12'hB00, 2'b00, 0, 64'hFFFF_FFFF, 1, 0, "rv32_mcycle_ones");
        acc32(12'hB80, 2'b00, 0, 64'h1234_5679, 1, 0, "rv32_mcycleh_carry");
        acc32(12'hB82, 2'b00, 0, 0, 1, 0, "rv32_minstreth");
        acc32(12'hF14, 2'b00, 0, 0, 1, 0, "rv32_mhartid");

        repeat (2) @(posedge clk);
        #1;
        check("csr_responses_left", 64'(exp_q.size()), 64'd0);
        check("redirects_left", 64'(redir_q.size()), 64'd0);
        check("csr32_responses_left", 64'(exp32_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
